nibble_abs_accum: RTL
=====================

// Module: nibble_abs_accum
// PURPOSE
//  Downstream consumer of the signed-nibble cast stage. It takes a stream of 4-bit two's-complement nibbles,
//  sign-extends each to 8 bits and forms its magnitude (a[3] ? -signed'(a) : a).
//  It accumulates per-frame sum-of-magnitudes and signed sum, then presents one result per frame over valid/ready.
//  It also serves as a cosim target for signed-cast width/extension semantics in sequential logic.
// PARAMETERS
//  NIB_W      4   input element width (two's complement)
//  EXT_W      8   sign-extension / magnitude width; must be > NIB_W
//  ACC_W      16  accumulator width (sum of magnitudes, unsigned, saturating)
//  FRAME_LEN  8   max beats per frame; a frame closes early on in_last
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid & in_ready
//  in_data    in   NIB_W  signed nibble
//  in_last    in   1      final beat of frame
//  out_valid  out  1      frame result valid
//  out_ready  in   1      result consumed when out_valid & out_ready
//  out_mag    out  ACC_W  saturated sum of EXT_W-bit magnitudes
//  out_ssum   out  ACC_W  signed sum of sign-extended beats (see CONFIGURATION)
//  out_count  out  $clog2(FRAME_LEN+1)  beats in frame
//  out_ovf    out  1      sticky: out_mag saturated during frame
// BEHAVIOUR
//  - Reset (async assert, sync deassert):
//    - state=IDLE; in_ready=1; out_valid=0; all accumulators, count, ovf and outputs = 0.
//  - FSM:
//    - IDLE: the first accepted beat goes to ACCUM. If that beat is closing (in_last or FRAME_LEN==1), go straight to HOLD.
//    - ACCUM: accept beats. A beat closes the frame if in_last=1 or count+1==FRAME_LEN; on a closing beat go to HOLD.
//    - HOLD: in_ready=0; out_valid=1, outputs stable. On out_ready go to IDLE, clearing accumulators the same edge.
//  - Latency: out_valid rises the cycle after the closing beat is accepted. Exactly one bubble follows each frame
//    (in_ready=0 in HOLD; in_ready=1 again the cycle after the handshake).
//  - Arithmetic:
//    - sext = {{EXT_W-NIB_W}{d[NIB_W-1]}, d}.
//    - mag = d[NIB_W-1] ? -sext : zero-extended d. So 4'h8 yields 8'd8, not -8.
//    - out_mag += mag, zero-extended to ACC_W+1. If the result exceeds 2^ACC_W-1, clamp to all-ones and set out_ovf.
//    - out_ssum wraps modulo 2^ACC_W (no saturation).
//  - Boundaries:
//    - in_valid low mid-frame: hold state, no timeout.
//    - FRAME_LEN reached without in_last: frame closes. The next beat starts a new frame regardless of its in_last.
//    - in_last together with the FRAME_LEN-th beat: single close.
//    - rst_n low mid-frame or in HOLD: partial result is discarded, out_valid drops immediately.
//    - out_ready while out_valid=0: ignored.
// CONFIGURATION
//  NIBBLE_ABS_ACCUM_SSUM_EN
//    - defined: the signed-sum accumulator is built; out_ssum is as above.
//    - undefined: the accumulator is omitted; out_ssum is tied to '0. The port always exists.
// STRUCTURE
//  - Package nibble_abs_accum_pkg holds:
//    - state_e {IDLE, ACCUM, HOLD} as a 2-bit typedef;
//    - parameters NIB_W and EXT_W;
//    - function automatic sext_nib(logic [NIB_W-1:0]).
//  - Sub-module nibble_abs (combinational): in d[NIB_W-1:0]; out sext[EXT_W-1:0], mag[EXT_W-1:0].
//    It uses signed'() casts with explicit widths.
//  - Top holds the FSM, count register, accumulators and the sticky ovf.
// TESTING
//  1 Frame 4'h1,4'hF,4'h8,4'h7(last) -> out_mag=17, out_ssum=-1 (16'hFFFF), count=4, ovf=0.
//  2 Eight beats of 4'h3 with in_last=0 -> frame closes on beat 8.
//    Result out_mag=24, count=8; next beat begins a new frame.
//  3 ACC_W=6, nine beats of 4'h8 (FRAME_LEN=16, last on 9th) -> out_mag=63 (6'h3F), ovf=1.
//  4 HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable.
//    out_ready=1 -> IDLE next cycle, beat accepted one cycle later.
//  5 rst_n pulsed low after 2 beats -> out_valid=0, count=0 asynchronously.
//    A following 1-beat frame 4'hC(last) gives out_mag=4.
//  6 Build without NIBBLE_ABS_ACCUM_SSUM_EN, rerun test 1 -> out_ssum=0, other outputs unchanged.

Source files
------------

// File: rtl/nibble_abs_accum_pkg.sv
// Shared widths, FSM state type and the nibble sign-extension helper for nibble_abs_accum.
package nibble_abs_accum_pkg;

  localparam int NIB_W = 4;
  localparam int EXT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [EXT_W-1:0] sext_nib(input logic [NIB_W-1:0] a);
    return EXT_W'(signed'(a));
  endfunction

endpackage

// File: rtl/nibble_abs.sv
// Combinational sign-extension and magnitude of one two's-complement nibble.
module nibble_abs
  import nibble_abs_accum_pkg::*;
(
  input  logic [NIB_W-1:0] d,
  output logic [EXT_W-1:0] sext,
  output logic [EXT_W-1:0] mag
);

  logic signed [EXT_W-1:0] w_sext_s;

  assign w_sext_s = EXT_W'(signed'(d));
  assign sext     = sext_nib(d);
  // Negating at EXT_W keeps the most negative nibble positive (4'h8 -> 8).
  assign mag      = d[NIB_W-1] ? EXT_W'(-w_sext_s) : EXT_W'(d);

endmodule

// File: rtl/nibble_abs_accum.sv
// Per-frame saturating sum of nibble magnitudes plus optional signed sum, one result per frame.
// Optional signed-sum accumulator: define NIBBLE_ABS_ACCUM_SSUM_EN; otherwise out_ssum reads zero.
module nibble_abs_accum
  import nibble_abs_accum_pkg::*;
#(
  parameter  int ACC_W     = 16,
  parameter  int FRAME_LEN = 8,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NIB_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_mag,
  output logic [ACC_W-1:0] out_ssum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output state_e           dbg_state
);

  // Handshakes: a beat/result transfers on a rising edge where valid and ready are both high;
  // valid never depends on ready, and ready here depends only on the registered state.

  localparam int SUM_W = ((ACC_W > EXT_W) ? ACC_W : EXT_W) + 1;

  state_e           r_state;
  state_e           w_state_nx;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_mag;
  logic             r_ovf;
  logic [EXT_W-1:0] w_sext;
  logic [EXT_W-1:0] w_mag;
  logic             w_accept;
  logic             w_clear;
  logic             w_close;
  logic [CNT_W-1:0] w_count_inc;
  logic [SUM_W-1:0] w_sum;
  logic             w_sat;

  nibble_abs u_abs (
    .d    (in_data),
    .sext (w_sext),
    .mag  (w_mag)
  );

  assign w_count_inc = r_count + CNT_W'(1);
  assign w_close     = in_last | (w_count_inc == CNT_W'(FRAME_LEN));
  assign w_sum       = SUM_W'(r_mag) + SUM_W'(w_mag);
  assign w_sat       = (w_sum > SUM_W'({ACC_W{1'b1}}));

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    w_accept   = 1'b0;
    w_clear    = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) w_state_nx = w_close ? HOLD : ACCUM;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nx = IDLE;
          w_clear    = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_mag   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_clear) begin
        r_count <= '0;
        r_mag   <= '0;
        r_ovf   <= 1'b0;
      end else if (w_accept) begin
        r_count <= w_count_inc;
        r_mag   <= w_sat ? '1 : w_sum[ACC_W-1:0];
        if (w_sat) r_ovf <= 1'b1;
      end
    end
  end

`ifdef NIBBLE_ABS_ACCUM_SSUM_EN
  logic [ACC_W-1:0] r_ssum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ssum <= '0;
    end else if (w_clear) begin
      r_ssum <= '0;
    end else if (w_accept) begin
      r_ssum <= r_ssum + ACC_W'(signed'(w_sext));
    end
  end

  assign out_ssum = r_ssum;
`else
  logic w_sext_unused;

  assign w_sext_unused = ^w_sext;
  assign out_ssum      = '0;
`endif

  assign out_mag   = r_mag;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;
  assign dbg_state = r_state;

endmodule
